// File: rtl/ahb_apb_bridge_n.sv
// AHB-Lite slave to APB3 master bridge: parametrised PSEL decode, PREADY wait states,
// PSLVERR-to-HRESP mapping and an APB access timeout. All outputs are registered.
module ahb_apb_bridge_n #(
    parameter int NUM_SLAVES = 16,
    parameter int ADDR_WIDTH = 32,
    parameter int SLOT_LSB   = 8,
    parameter int TIMEOUT    = 256
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADYIN,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic                  PENABLE,
    output logic [31:0]           PWDATA,
    input  logic [31:0]           PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic                  TIMEOUT_EVT
);

    localparam int               CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit               TIMEOUT_EN = (TIMEOUT > 0);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [3:0]              slot_q, slot_d;
    logic                    write_q, write_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic                    penable_q, penable_d;
    logic [31:0]             pwdata_q, pwdata_d;
    logic [31:0]             hrdata_q, hrdata_d;
    logic                    hreadyout_q, hreadyout_d;
    logic                    hresp_q, hresp_d;
    logic                    tmo_evt_q, tmo_evt_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    accept;
    logic [NUM_SLAVES-1:0]   slot_onehot;
    logic                    slot_hit;
    logic                    unused_bits;

    assign accept      = HSEL & HTRANS[1] & HREADYIN & hreadyout_q;
    assign unused_bits = ^{HTRANS[0], HADDR};

    // A slot at or beyond NUM_SLAVES matches no bit, which is what flags a decode miss.
    always_comb begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
            slot_onehot[i] = (slot_q == 4'(i));
        end
    end
    assign slot_hit = |slot_onehot;

    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        slot_d      = slot_q;
        write_d     = write_q;
        psel_d      = psel_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        penable_d   = penable_q;
        pwdata_d    = pwdata_q;
        hrdata_d    = hrdata_q;
        hreadyout_d = hreadyout_q;
        hresp_d     = hresp_q;
        tmo_evt_d   = 1'b0;
        cnt_d       = cnt_q;

        case (state_q)
            ST_IDLE: begin
                hreadyout_d = 1'b1;
                hresp_d     = 1'b0;
                if (accept) begin
                    addr_d      = HADDR[ADDR_WIDTH-1:0];
                    slot_d      = HADDR[SLOT_LSB +: 4];
                    write_d     = HWRITE;
                    hreadyout_d = 1'b0;
                    state_d     = ST_LATCH;
                end
            end
            ST_LATCH: begin
                paddr_d  = addr_q;
                pwrite_d = write_q;
                if (write_q) begin
                    pwdata_d = HWDATA;
                end
                if (slot_hit) begin
                    psel_d  = slot_onehot;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_ERR1;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    if (PSLVERR) begin
                        state_d = ST_ERR1;
                    end else begin
                        if (!write_q) begin
                            hrdata_d = PRDATA;
                        end
                        hreadyout_d = 1'b1;
                        state_d     = ST_IDLE;
                    end
                end else begin
                    cnt_d = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
                    // cnt_q counts completed wait cycles, so CNT_LAST here is the TIMEOUT-th one.
                    if (TIMEOUT_EN && (cnt_q == CNT_LAST)) begin
                        psel_d    = '0;
                        penable_d = 1'b0;
                        tmo_evt_d = 1'b1;
                        state_d   = ST_ERR1;
                    end
                end
            end
            ST_ERR1: begin
                hresp_d     = 1'b1;
                hreadyout_d = 1'b0;
                state_d     = ST_ERR2;
            end
            ST_ERR2: begin
                hresp_d     = 1'b1;
                hreadyout_d = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            slot_q      <= '0;
            write_q     <= 1'b0;
            psel_q      <= '0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            penable_q   <= 1'b0;
            pwdata_q    <= '0;
            hrdata_q    <= '0;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            tmo_evt_q   <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            slot_q      <= slot_d;
            write_q     <= write_d;
            psel_q      <= psel_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            penable_q   <= penable_d;
            pwdata_q    <= pwdata_d;
            hrdata_q    <= hrdata_d;
            hreadyout_q <= hreadyout_d;
            hresp_q     <= hresp_d;
            tmo_evt_q   <= tmo_evt_d;
            cnt_q       <= cnt_d;
        end
    end

    assign HREADYOUT   = hreadyout_q;
    assign HRESP       = hresp_q;
    assign HRDATA      = hrdata_q;
    assign PSEL        = psel_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PENABLE     = penable_q;
    assign PWDATA      = pwdata_q;
    assign TIMEOUT_EVT = tmo_evt_q;

endmodule

// File: tb/tb_ahb_apb_bridge_n.sv
// Self-checking bench for ahb_apb_bridge_n: directed scenarios plus randomized transfers
// checked against a transfer-level reference model of the bridge's response.
module tb_ahb_apb_bridge_n;

    localparam int NS = 6;
    localparam int TO = 8;
    localparam int AW = 32;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADYIN;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [NS-1:0] PSEL;
    logic [AW-1:0] PADDR;
    logic          PWRITE;
    logic          PENABLE;
    logic [31:0]   PWDATA;
    logic [31:0]   PRDATA;
    logic          PREADY;
    logic          PSLVERR;
    logic          TIMEOUT_EVT;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model of the bridge's architecturally visible registers.
    logic [31:0]   m_hrdata;
    logic [AW-1:0] m_paddr;
    logic [31:0]   m_pwdata;
    logic          m_pwrite;

    ahb_apb_bridge_n #(
        .NUM_SLAVES(NS),
        .ADDR_WIDTH(AW),
        .SLOT_LSB  (8),
        .TIMEOUT   (TO)
    ) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADYIN   (HREADYIN),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .PSEL       (PSEL),
        .PADDR      (PADDR),
        .PWRITE     (PWRITE),
        .PENABLE    (PENABLE),
        .PWDATA     (PWDATA),
        .PRDATA     (PRDATA),
        .PREADY     (PREADY),
        .PSLVERR    (PSLVERR),
        .TIMEOUT_EVT(TIMEOUT_EVT)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_hrdata = '0;
        m_paddr  = '0;
        m_pwdata = '0;
        m_pwrite = 1'b0;
    endtask

    task automatic bus_idle();
        HSEL     = 1'b0;
        HTRANS   = 2'b00;
        HREADYIN = 1'b1;
    endtask

    task automatic check_regs(input string tag);
        n_vec++; if (HRDATA !== m_hrdata) begin n_bad++; $display("FAIL %s hrdata: got %h want %h", tag, HRDATA, m_hrdata); end
        n_vec++; if (PADDR !== m_paddr) begin n_bad++; $display("FAIL %s paddr: got %h want %h", tag, PADDR, m_paddr); end
        n_vec++; if (PWDATA !== m_pwdata) begin n_bad++; $display("FAIL %s pwdata: got %h want %h", tag, PWDATA, m_pwdata); end
        n_vec++; if (PWRITE !== m_pwrite) begin n_bad++; $display("FAIL %s pwrite: got %b want %b", tag, PWRITE, m_pwrite); end
    endtask

    // One AHB transfer plus the APB slave's behaviour; entered and left at a negedge with HREADYOUT=1.
    // rst_at > 0 asserts HRESET in that cycle of the transfer instead of completing it.
    task automatic do_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wdata,
                           input int waits, input logic err, input logic [31:0] rdata,
                           input int rst_at, input string tag);
        int            slot, acc_exp, low_exp, n, acc, low, hresp_low, pen, evt, first_psel, first_pen;
        logic          hit, tmo, error, done, hresp_end, bad_psel;
        logic [NS-1:0] psel_exp, psel_or;

        slot     = int'(addr[11:8]);
        hit      = (slot < NS);
        tmo      = hit && (waits >= TO);
        error    = !hit || tmo || err;
        acc_exp  = !hit ? 0 : (tmo ? TO : waits + 1);
        low_exp  = !hit ? 3 : (error ? acc_exp + 4 : acc_exp + 2);
        psel_exp = hit ? (NS'(1) << slot) : '0;

        n = 0; acc = 0; low = 0; hresp_low = 0; pen = 0; evt = 0; first_psel = 0; first_pen = 0;
        done = 1'b0; hresp_end = 1'b0; bad_psel = 1'b0; psel_or = '0;

        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HREADYIN = 1'b1;

        while (!done && n < 64) begin
            @(negedge HCLK);
            n++;
            if (n == 1) begin
                HTRANS = 2'b00; HSEL = 1'($urandom); HADDR = $urandom; HWRITE = 1'($urandom);
                HWDATA = wdata;
            end else begin
                HWDATA = $urandom;
            end
            if (rst_at == n) begin
                n_vec++; if (PSEL !== psel_exp) begin n_bad++; $display("FAIL %s psel_before_reset: got %b want %b", tag, PSEL, psel_exp); end
                HRESET = 1'b1;
                #1;
                n_vec++; if (PSEL !== '0) begin n_bad++; $display("FAIL %s psel_async_reset: got %b want 0", tag, PSEL); end
                n_vec++; if (PENABLE !== 1'b0) begin n_bad++; $display("FAIL %s penable_async_reset: got %b want 0", tag, PENABLE); end
                n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_bad++; $display("FAIL %s resp_async_reset: got rdy=%b resp=%b want rdy=1 resp=0", tag, HREADYOUT, HRESP); end
                @(negedge HCLK);
                HRESET = 1'b0;
                model_reset();
                bus_idle();
                return;
            end
            if (PSEL !== '0) begin
                psel_or |= PSEL;
                if (PSEL !== psel_exp) bad_psel = 1'b1;
                if (first_psel == 0) first_psel = n;
            end
            if (PENABLE) begin
                pen++;
                if (first_pen == 0) first_pen = n;
            end
            if (TIMEOUT_EVT) evt++;
            if (HREADYOUT) begin
                done      = 1'b1;
                hresp_end = HRESP;
            end else begin
                low++;
                if (HRESP) hresp_low++;
            end
            if (PSEL !== '0 && PENABLE) begin
                acc++;
                PREADY  = (acc > waits);
                PSLVERR = err & PREADY;
                PRDATA  = PREADY ? rdata : $urandom;
            end else begin
                PREADY  = 1'($urandom);
                PSLVERR = 1'($urandom);
                PRDATA  = $urandom;
            end
        end

        n_vec++; if (!done) begin n_bad++; $display("FAIL %s completion: got none within 64 cycles want HREADYOUT=1", tag); end
        n_vec++; if (low != low_exp) begin n_bad++; $display("FAIL %s hreadyout_low_cycles: got %0d want %0d", tag, low, low_exp); end
        n_vec++; if (hresp_low != (error ? 1 : 0)) begin n_bad++; $display("FAIL %s err1_cycles: got %0d want %0d", tag, hresp_low, error ? 1 : 0); end
        n_vec++; if (hresp_end !== error) begin n_bad++; $display("FAIL %s final_hresp: got %b want %b", tag, hresp_end, error); end
        n_vec++; if (psel_or !== psel_exp || bad_psel) begin n_bad++; $display("FAIL %s psel: got %b (stray=%b) want %b", tag, psel_or, bad_psel, psel_exp); end
        n_vec++; if (pen != acc_exp) begin n_bad++; $display("FAIL %s penable_cycles: got %0d want %0d", tag, pen, acc_exp); end
        n_vec++; if (first_psel != (hit ? 2 : 0) || first_pen != (hit ? 3 : 0)) begin n_bad++; $display("FAIL %s apb_phase_timing: got psel@%0d penable@%0d want %0d/%0d", tag, first_psel, first_pen, hit ? 2 : 0, hit ? 3 : 0); end
        n_vec++; if (evt != (tmo ? 1 : 0)) begin n_bad++; $display("FAIL %s timeout_evt_pulses: got %0d want %0d", tag, evt, tmo ? 1 : 0); end

        m_paddr  = addr[AW-1:0];
        m_pwrite = wr;
        if (wr) m_pwdata = wdata;
        if (hit && !error && !wr) m_hrdata = rdata;
        check_regs(tag);

        if (error) begin
            @(negedge HCLK);
            n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_bad++; $display("FAIL %s post_error_idle: got rdy=%b resp=%b want rdy=1 resp=0", tag, HREADYOUT, HRESP); end
        end
        bus_idle();
    endtask

    task automatic test_reset();
        bus_idle();
        HADDR = '0; HWRITE = 1'b0; HWDATA = '0;
        PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = '0;
        HRESET = 1'b1;
        model_reset();
        repeat (3) @(negedge HCLK);
        n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0) begin n_bad++; $display("FAIL reset resp: got rdy=%b resp=%b want rdy=1 resp=0", HREADYOUT, HRESP); end
        n_vec++; if (PSEL !== '0 || PENABLE !== 1'b0 || TIMEOUT_EVT !== 1'b0) begin n_bad++; $display("FAIL reset apb_ctrl: got psel=%b pen=%b evt=%b want 0", PSEL, PENABLE, TIMEOUT_EVT); end
        check_regs("reset");
        HRESET = 1'b0;
        @(negedge HCLK);
    endtask

    task automatic test_no_accept();
        logic [1:0] tr [3];
        logic       sel [3];
        logic       rin [3];
        tr[0] = 2'b10; sel[0] = 1'b0; rin[0] = 1'b1;
        tr[1] = 2'b01; sel[1] = 1'b1; rin[1] = 1'b1;
        tr[2] = 2'b11; sel[2] = 1'b1; rin[2] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            HSEL = sel[i]; HTRANS = tr[i]; HREADYIN = rin[i]; HADDR = 32'h0000_0104; HWRITE = 1'b1;
            repeat (2) begin
                @(negedge HCLK);
                n_vec++; if (HREADYOUT !== 1'b1 || HRESP !== 1'b0 || PSEL !== '0) begin n_bad++; $display("FAIL no_accept%0d: got rdy=%b resp=%b psel=%b want 1/0/0", i, HREADYOUT, HRESP, PSEL); end
            end
        end
        bus_idle();
        @(negedge HCLK);
    endtask

    task automatic test_write_zero_wait();
        do_xfer(32'h0000_0204, 1'b1, 32'hA5A5_0001, 0, 1'b0, 32'h0, 0, "write_slot2");
    endtask

    task automatic test_read_waits();
        do_xfer(32'h0000_0504, 1'b0, 32'h0, 4, 1'b0, 32'h1234_5678, 0, "read_slot5_w4");
    endtask

    task automatic test_slverr();
        do_xfer(32'h0000_0310, 1'b0, 32'h0, 0, 1'b1, 32'hDEAD_BEEF, 0, "read_slverr");
    endtask

    task automatic test_decode_miss();
        do_xfer(32'h0000_0900, 1'b1, 32'h5555_AAAA, 0, 1'b0, 32'h0, 0, "decode_miss_slot9");
        do_xfer(32'h0000_0604, 1'b0, 32'h0, 0, 1'b0, 32'h0BAD_0BAD, 0, "decode_miss_slot6");
    endtask

    task automatic test_timeout();
        do_xfer(32'h0000_0108, 1'b0, 32'h0, 50, 1'b0, 32'h7777_7777, 0, "timeout");
        do_xfer(32'h0000_010C, 1'b0, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 0, "after_timeout");
        do_xfer(32'h0000_0400, 1'b1, 32'h0101_0101, TO - 1, 1'b0, 32'h0, 0, "max_wait_no_timeout");
    endtask

    task automatic test_back_to_back();
        do_xfer(32'h0000_0100, 1'b1, 32'h1111_1111, 0, 1'b0, 32'h0, 0, "b2b_first");
        do_xfer(32'h0000_0304, 1'b1, 32'h2222_2222, 0, 1'b0, 32'h0, 2, "b2b_second_reset");
        check_regs("after_reset");
        do_xfer(32'h0000_0008, 1'b0, 32'h0, 1, 1'b0, 32'h3333_3333, 0, "after_reset_read");
    endtask

    task automatic test_random();
        logic [31:0] addr;
        for (int i = 0; i < 40; i++) begin
            addr        = $urandom;
            addr[11:8]  = 4'($urandom_range(0, 15));
            do_xfer(addr, 1'($urandom), $urandom, int'($urandom_range(0, 10)),
                    ($urandom_range(0, 4) == 0), $urandom, 0, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 1) @(negedge HCLK);
        end
    endtask

    initial begin
        test_reset();
        test_no_accept();
        test_write_zero_wait();
        test_read_waits();
        test_slverr();
        test_decode_miss();
        test_timeout();
        test_back_to_back();
        test_random();
        repeat (2) @(negedge HCLK);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
